// File: rtl/execute_stage_if.sv
// D/E-side inputs and E/M-side outputs of the execute stage.
// The DUT attaches through the slave modport and the driver through the master modport.
interface execute_stage_if #(
    parameter int W   = 16,
    parameter int SHW = 4
);
    logic [3:0]     mem_sig_i;
    logic [5:0]     ex_sig_i;
    logic [2:0]     wb_sig_i;
    logic [W-1:0]   rsrc_i;
    logic [W-1:0]   rdst_i;
    logic [SHW-1:0] shamt_i;
    logic [W-1:0]   imm_i;
    logic           valid_i;
    logic           stall;
    logic           flush;

    logic [3:0]     mem_sig_o;
    logic [2:0]     wb_sig_o;
    logic [W-1:0]   alu_out_o;
    logic [W-1:0]   rsrc_o;
    logic [W-1:0]   rdst_o;
    logic [W-1:0]   imm_o;
    logic           valid_o;
    logic [2:0]     flags_o;

    modport master (
        output mem_sig_i, ex_sig_i, wb_sig_i, rsrc_i, rdst_i, shamt_i, imm_i,
               valid_i, stall, flush,
        input  mem_sig_o, wb_sig_o, alu_out_o, rsrc_o, rdst_o, imm_o, valid_o, flags_o
    );

    modport slave (
        input  mem_sig_i, ex_sig_i, wb_sig_i, rsrc_i, rdst_i, shamt_i, imm_i,
               valid_i, stall, flush,
        output mem_sig_o, wb_sig_o, alu_out_o, rsrc_o, rdst_o, imm_o, valid_o, flags_o
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, condition-code register {Z,N,C} and the E/M pipeline register.
module execute_stage #(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);
    logic [W-1:0]   a, b, r;
    logic [SHW-1:0] sh;
    logic [W:0]     sum_w, diff_w, inc_w, dec_w, shl_w, shr_w;
    logic           upd_zn, upd_c, c_new;
    logic [2:0]     flags_next;

    logic [3:0]   mem_q,   mem_d;
    logic [2:0]   wb_q,    wb_d;
    logic [W-1:0] alu_q,   alu_d;
    logic [W-1:0] rsrc_q,  rsrc_d;
    logic [W-1:0] rdst_q,  rdst_d;
    logic [W-1:0] imm_q,   imm_d;
    logic         valid_q, valid_d;
    logic [2:0]   ccr_q,   ccr_d;

    // ALU result and candidate flag values for the instruction in the D/E slot
    always_comb begin
        a      = bus.rsrc_i;
        b      = bus.ex_sig_i[0] ? bus.rdst_i : {{(W-SHW){1'b0}}, bus.shamt_i};
        sh     = b[SHW-1:0];
        sum_w  = {1'b0, a} + {1'b0, b};
        diff_w = {1'b0, a} - {1'b0, b};
        inc_w  = {1'b0, a} + {{W{1'b0}}, 1'b1};
        dec_w  = {1'b0, a} - {{W{1'b0}}, 1'b1};
        // Extra bit above/below the word catches the last bit shifted out
        shl_w  = {1'b0, a} << sh;
        shr_w  = {a, 1'b0} >> sh;
        r      = a;
        upd_zn = 1'b0;
        upd_c  = 1'b0;
        c_new  = ccr_q[0];
        if (bus.ex_sig_i[1]) begin
            case (bus.ex_sig_i[5:2])
                4'd1:  begin upd_c = 1'b1; c_new = 1'b1; end
                4'd2:  begin upd_c = 1'b1; c_new = 1'b0; end
                4'd3:  begin r = ~a; upd_zn = 1'b1; end
                4'd4:  begin r = inc_w[W-1:0];  upd_zn = 1'b1; upd_c = 1'b1; c_new = inc_w[W];  end
                4'd5:  begin r = dec_w[W-1:0];  upd_zn = 1'b1; upd_c = 1'b1; c_new = dec_w[W];  end
                4'd6:  r = b;
                4'd7:  begin r = sum_w[W-1:0];  upd_zn = 1'b1; upd_c = 1'b1; c_new = sum_w[W];  end
                4'd8:  begin r = diff_w[W-1:0]; upd_zn = 1'b1; upd_c = 1'b1; c_new = diff_w[W]; end
                4'd9:  begin r = a & b; upd_zn = 1'b1; end
                4'd10: begin r = a | b; upd_zn = 1'b1; end
                4'd11: begin
                    r = shl_w[W-1:0]; upd_zn = 1'b1;
                    if (sh != '0) begin upd_c = 1'b1; c_new = shl_w[W]; end
                end
                4'd12: begin
                    r = shr_w[W:1]; upd_zn = 1'b1;
                    if (sh != '0) begin upd_c = 1'b1; c_new = shr_w[0]; end
                end
                default: r = a;
            endcase
        end
        flags_next = {upd_zn ? (r == '0) : ccr_q[2],
                      upd_zn ? r[W-1]    : ccr_q[1],
                      upd_c  ? c_new     : ccr_q[0]};
    end

    // Next E/M register and CCR: flush beats stall, stall beats bubble, else load
    always_comb begin
        mem_d   = mem_q;
        wb_d    = wb_q;
        alu_d   = alu_q;
        rsrc_d  = rsrc_q;
        rdst_d  = rdst_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        ccr_d   = ccr_q;
        if (bus.flush || (!bus.stall && !bus.valid_i)) begin
            mem_d   = '0;
            wb_d    = '0;
            alu_d   = '0;
            rsrc_d  = '0;
            rdst_d  = '0;
            imm_d   = '0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            mem_d   = bus.mem_sig_i;
            wb_d    = bus.wb_sig_i;
            alu_d   = r;
            rsrc_d  = bus.rsrc_i;
            rdst_d  = bus.rdst_i;
            imm_d   = bus.imm_i;
            valid_d = 1'b1;
            ccr_d   = flags_next;
        end
    end

    // E/M register and CCR state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wb_q    <= '0;
            alu_q   <= '0;
            rsrc_q  <= '0;
            rdst_q  <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            ccr_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            alu_q   <= alu_d;
            rsrc_q  <= rsrc_d;
            rdst_q  <= rdst_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            ccr_q   <= ccr_d;
        end
    end

    assign bus.mem_sig_o = mem_q;
    assign bus.wb_sig_o  = wb_q;
    assign bus.alu_out_o = alu_q;
    assign bus.rsrc_o    = rsrc_q;
    assign bus.rdst_o    = rdst_q;
    assign bus.imm_o     = imm_q;
    assign bus.valid_o   = valid_q;
    assign bus.flags_o   = ccr_q;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors with hand-computed results.
module tb_execute_stage;
    typedef struct packed {
        logic [3:0]  mem;
        logic [2:0]  wb;
        logic [15:0] alu;
        logic [15:0] rsrc;
        logic [15:0] rdst;
        logic [15:0] imm;
        logic        valid;
        logic [2:0]  flags;
    } em_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    em_t  exp_q[$];
    em_t  last;

    execute_stage_if #(.W(16), .SHW(4)) bus ();
    execute_stage #(.W(16), .SHW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic em_t get_act();
        em_t t;
        t.mem   = bus.mem_sig_o;
        t.wb    = bus.wb_sig_o;
        t.alu   = bus.alu_out_o;
        t.rsrc  = bus.rsrc_o;
        t.rdst  = bus.rdst_o;
        t.imm   = bus.imm_o;
        t.valid = bus.valid_o;
        t.flags = bus.flags_o;
        return t;
    endfunction

    // Monitor: after each edge, compare DUT outputs with the oldest expected entry
    always @(posedge clk) begin
        em_t e, act;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = get_act();
            n_txn++;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL txn%0d: got mem=%h wb=%h alu=%h rsrc=%h rdst=%h imm=%h v=%b f=%b, expected mem=%h wb=%h alu=%h rsrc=%h rdst=%h imm=%h v=%b f=%b",
                         n_txn, act.mem, act.wb, act.alu, act.rsrc, act.rdst, act.imm, act.valid, act.flags,
                         e.mem, e.wb, e.alu, e.rsrc, e.rdst, e.imm, e.valid, e.flags);
            end
        end
    end

    task automatic check_zero(input string name);
        em_t act;
        act = get_act();
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h, expected all zero", name, act);
        end
    endtask

    // Apply one instruction at a falling edge, record the expected E/M contents, wait one cycle
    task automatic drive(input logic [3:0] mem, input logic [2:0] wb, input logic [3:0] op,
                         input logic en, input logic shs, input logic [15:0] a,
                         input logic [15:0] rd, input logic [3:0] sh, input logic [15:0] im,
                         input logic v, input logic st, input logic fl,
                         input logic [15:0] ea, input logic [2:0] ef);
        em_t e;
        bus.mem_sig_i = mem;
        bus.wb_sig_i  = wb;
        bus.ex_sig_i  = {op, en, shs};
        bus.rsrc_i    = a;
        bus.rdst_i    = rd;
        bus.shamt_i   = sh;
        bus.imm_i     = im;
        bus.valid_i   = v;
        bus.stall     = st;
        bus.flush     = fl;
        if (fl || (!st && !v)) begin
            e = '0;
            e.flags = last.flags;
        end else if (st) begin
            e = last;
        end else begin
            e = '{mem: mem, wb: wb, alu: ea, rsrc: a, rdst: rd, imm: im, valid: 1'b1, flags: ef};
        end
        exp_q.push_back(e);
        last = e;
        @(negedge clk);
    endtask

    task automatic alu(input logic [3:0] op, input logic shs, input logic [15:0] a,
                       input logic [15:0] rd, input logic [3:0] sh,
                       input logic [15:0] ea, input logic [2:0] ef);
        drive(4'h0, 3'h0, op, 1'b1, shs, a, rd, sh, 16'h0, 1'b1, 1'b0, 1'b0, ea, ef);
    endtask

    initial begin
        last = '0;
        bus.mem_sig_i = '0; bus.wb_sig_i = '0; bus.ex_sig_i = '0;
        bus.rsrc_i = '0; bus.rdst_i = '0; bus.shamt_i = '0; bus.imm_i = '0;
        bus.valid_i = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        #2;
        check_zero("reset_initial");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // op, shamSel, A, Rdst, shamt, expected R, expected {Z,N,C}
        alu(4'd7,  1'b0, 16'h0003, 16'h0000, 4'd4, 16'h0007, 3'b000);
        alu(4'd7,  1'b1, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 3'b101);
        alu(4'd1,  1'b0, 16'h0055, 16'h0000, 4'd0, 16'h0055, 3'b101);
        alu(4'd2,  1'b0, 16'h0066, 16'h0000, 4'd0, 16'h0066, 3'b100);
        alu(4'd8,  1'b1, 16'h0002, 16'h0005, 4'd0, 16'hFFFD, 3'b011);
        alu(4'd8,  1'b1, 16'h0005, 16'h0005, 4'd0, 16'h0000, 3'b100);
        alu(4'd11, 1'b0, 16'h8001, 16'h0000, 4'd1, 16'h0002, 3'b001);
        alu(4'd12, 1'b0, 16'h0003, 16'h0000, 4'd2, 16'h0000, 3'b101);
        alu(4'd11, 1'b0, 16'h8000, 16'h0000, 4'd0, 16'h8000, 3'b011);
        alu(4'd4,  1'b0, 16'hFFFF, 16'h0000, 4'd0, 16'h0000, 3'b101);
        alu(4'd5,  1'b0, 16'h0000, 16'h0000, 4'd0, 16'hFFFF, 3'b011);
        alu(4'd3,  1'b0, 16'h00FF, 16'h0000, 4'd0, 16'hFF00, 3'b011);
        alu(4'd9,  1'b1, 16'hF0F0, 16'h0F0F, 4'd0, 16'h0000, 3'b101);
        alu(4'd10, 1'b1, 16'h8000, 16'h0001, 4'd0, 16'h8001, 3'b011);
        alu(4'd6,  1'b1, 16'h0001, 16'h1234, 4'd0, 16'h1234, 3'b011);
        // ALU disabled: R=A, flags held
        drive(4'h0, 3'h0, 4'd7, 1'b0, 1'b1, 16'h0009, 16'h0001, 4'd0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0009, 3'b011);
        alu(4'd13, 1'b0, 16'h000A, 16'h0000, 4'd0, 16'h000A, 3'b011);

        // Stall twice, then stall+flush, then the ADD goes through
        drive(4'h0, 3'h0, 4'd7, 1'b1, 1'b0, 16'h0001, 16'h0, 4'd1, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0002, 3'b000);
        drive(4'h0, 3'h0, 4'd7, 1'b1, 1'b0, 16'h0001, 16'h0, 4'd1, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0002, 3'b000);
        drive(4'h0, 3'h0, 4'd7, 1'b1, 1'b0, 16'h0001, 16'h0, 4'd1, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0002, 3'b000);
        drive(4'h0, 3'h0, 4'd7, 1'b1, 1'b0, 16'h0001, 16'h0, 4'd1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0002, 3'b000);

        // Pass-through, then a bubble
        drive(4'b1010, 3'b101, 4'd0, 1'b1, 1'b0, 16'h4321, 16'h5678, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h4321, 3'b000);
        drive(4'b1010, 3'b101, 4'd0, 1'b1, 1'b0, 16'h4321, 16'h5678, 4'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
        alu(4'd7,  1'b1, 16'h8000, 16'h8000, 4'd0, 16'h0000, 3'b101);

        // Asynchronous reset mid-run while an instruction is on the inputs
        bus.ex_sig_i = {4'd7, 1'b1, 1'b0};
        bus.rsrc_i   = 16'h0003;
        bus.rdst_i   = 16'h0000;
        bus.shamt_i  = 4'd4;
        bus.valid_i  = 1'b1;
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        @(negedge clk);
        check_zero("reset_held");
        rst  = 1'b0;
        last = '0;
        alu(4'd7,  1'b0, 16'h0003, 16'h0000, 4'd4, 16'h0007, 3'b000);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
